// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between N_REQ byte sources.
//
// When idle, the arbiter picks the next pending requester starting at the round-robin
// pointer. It latches that requester's byte, pulses o_tx_start and o_grant_ack for one
// cycle, and waits for i_tx_done. It then holds off for GAP_CYCLES idle cycles before it
// grants again.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   i_req        per-requester valid, held until the matching o_grant_ack
//   i_req_data   requester k byte at [k*DATA_W +: DATA_W]
//   o_grant_ack  one-hot, 1-cycle pulse: byte of requester k accepted
//   o_tx_start   1-cycle start pulse to the UART
//   o_tx_data    byte to the UART, stable from o_tx_start until the next grant
//   i_tx_done    frame-complete pulse from the UART
//   o_busy       high in every state except idle
//   o_cur_id     index of the last granted requester
//   o_timeout    1-cycle pulse on watchdog expiry
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog of
// TIMEOUT_CYCLES cycles. Without it, o_timeout is tied low and the arbiter waits
// indefinitely for i_tx_done.

module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  localparam int unsigned ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_grant_ack,
  output logic                    o_tx_start,
  output logic [DATA_W-1:0]       o_tx_data,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic [ID_W-1:0]         o_cur_id,
  output logic                    o_timeout
);

  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StGap} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [GapW-1:0]   gap_cnt_q;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   scan_id;
  logic [N_REQ-1:0]  win_grant;
  logic [DATA_W-1:0] win_data;
  logic [ID_W-1:0]   next_ptr;
  logic              wd_expired;

  // Round-robin search: walk rr_ptr, rr_ptr+1, ... with wrap at N_REQ-1 and take the
  // first set request bit.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_grant = '0;
    win_data  = '0;
    scan_id   = rr_ptr_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!win_found && i_req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
      scan_id = (scan_id == ID_W'(N_REQ - 1)) ? '0 : scan_id + ID_W'(1);
    end
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (win_id == ID_W'(k)) begin
        win_grant[k] = win_found;
        win_data     = i_req_data[k*DATA_W +: DATA_W];
      end
    end
    next_ptr = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [WdW-1:0] wd_q;

  // The cycle in WAIT_DONE that brings the count to TIMEOUT_CYCLES; a done pulse in the
  // same cycle takes priority.
  assign wd_expired = !i_tx_done && (wd_q == WdW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      o_grant_ack <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_busy      <= 1'b0;
      o_cur_id    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_q        <= '0;
      o_timeout   <= 1'b0;
`endif
    end else begin
      o_grant_ack <= '0;
      o_tx_start  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      o_timeout   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            o_tx_data   <= win_data;
            o_cur_id    <= win_id;
            o_tx_start  <= 1'b1;
            o_grant_ack <= win_grant;
            o_busy      <= 1'b1;
            rr_ptr_q    <= next_ptr;
            state_q     <= StStart;
          end
        end
        StStart: begin
          // i_tx_done is deliberately not looked at here.
          state_q <= StWaitDone;
`ifdef UART_ARB_TIMEOUT_EN
          wd_q    <= '0;
`endif
        end
        StWaitDone: begin
          if (i_tx_done || wd_expired) begin
            if (GAP_CYCLES == 0) begin
              state_q <= StIdle;
              o_busy  <= 1'b0;
            end else begin
              gap_cnt_q <= GapW'(GAP_CYCLES);
              state_q   <= StGap;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          o_timeout <= wd_expired;
          wd_q      <= wd_expired ? '0 : wd_q + WdW'(1);
`endif
        end
        StGap: begin
          gap_cnt_q <= gap_cnt_q - GapW'(1);
          if (gap_cnt_q == GapW'(1)) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (N_REQ=4, DATA_W=8, GAP_CYCLES=16, TIMEOUT_CYCLES=50).
// Expected grants are pushed to a scoreboard queue when requests are driven and popped
// when o_tx_start is seen. Inputs change and outputs are sampled on the falling edge.

module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 16;
  localparam int TMO = 50;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           tx_done;
  logic [N-1:0]   grant_ack;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           busy;
  logic [1:0]     cur_id;
  logic           timeout;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .DATA_W         (W),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req),
    .i_req_data  (req_data),
    .o_grant_ack (grant_ack),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .i_tx_done   (tx_done),
    .o_busy      (busy),
    .o_cur_id    (cur_id),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < N; k++) req_data[k*W +: W] = base + 8'(k);
  endtask

  // Bounded wait for o_tx_start; lat is the number of falling edges waited.
  task automatic wait_start(output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
  endtask

  // Called in the START cycle: done after d cycles, then wait (bounded) for idle.
  task automatic finish_frame(input int d);
    bit idle;
    repeat (d) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < GAP + 8; i++) begin
      if (busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!idle) begin
      n_fail++;
      $display("FAIL frame_idle: busy=%b still after gap, required 0", busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req      = 4'b1111;
    tx_done  = 1'b0;
    set_data(8'h10);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_start, busy, timeout} !== 3'b000 || grant_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: start=%b busy=%b tmo=%b ack=%b, required all 0",
               tx_start, busy, timeout, grant_ack);
    end
    n_checks++;
    if (tx_data !== 8'h00 || cur_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h id=%0d, required 00 and 0", tx_data, cur_id);
    end
    req = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    exp_t e;
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    push_exp(0, 8'hA5);
    wait_start(ok, lat);
    n_checks++;
    if (!ok || lat != 1) begin
      n_fail++;
      $display("FAIL single_latency: seen=%b lat=%0d, required seen in 1 cycle", ok, lat);
    end
    e = sb.pop_front();
    n_checks++;
    if (cur_id !== 2'(e.id) || tx_data !== e.data || grant_ack !== (4'b0001 << e.id)) begin
      n_fail++;
      $display("FAIL single_grant: id=%0d data=%h ack=%b, required id=%0d data=%h ack=%b",
               cur_id, tx_data, grant_ack, e.id, e.data, 4'b0001 << e.id);
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b0 || grant_ack !== 4'b0000 || busy !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_wait: start=%b ack=%b busy=%b data=%h, required 0 0000 1 a5",
               tx_start, grant_ack, busy, tx_data);
    end
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (GAP - 1) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gap_end: busy=%b at gap cycle %0d, required 1", busy, GAP);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_data !== 8'hA5 || cur_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b data=%h id=%0d, required 0 a5 0", busy, tx_data,
               cur_id);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int lat;
    int prev_cyc;
    int prev_d;
    exp_t e;
    do_reset();
    set_data(8'h10);
    req = 4'b1111;
    prev_cyc = 0;
    prev_d   = 0;
    for (int g = 0; g < 5; g++) begin
      push_exp(g % N, 8'h10 + 8'(g % N));
      wait_start(ok, lat);
      e = sb.pop_front();
      n_checks++;
      if (!ok || cur_id !== 2'(e.id) || tx_data !== e.data ||
          grant_ack !== (4'b0001 << e.id)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: seen=%b id=%0d data=%h ack=%b, required id=%0d data=%h",
                 g, ok, cur_id, tx_data, grant_ack, e.id, e.data);
      end
      if (g > 0) begin
        n_checks++;
        if (cyc - prev_cyc != prev_d + GAP + 2) begin
          n_fail++;
          $display("FAIL rr_spacing%0d: %0d cycles, required %0d", g, cyc - prev_cyc,
                   prev_d + GAP + 2);
        end
      end
      prev_cyc = cyc;
      prev_d   = 1 + g;
      if (g == 4) req = 4'b0000;
      finish_frame(prev_d);
    end
  endtask

  task automatic test_pointer_fairness();
    bit ok;
    int lat;
    exp_t e;
    int ids[3];
    logic [3:0] reqs[3];
    ids  = '{2, 0, 2};
    reqs = '{4'b0100, 4'b0101, 4'b0100};
    do_reset();
    set_data(8'h20);
    for (int g = 0; g < 3; g++) begin
      req = reqs[g];
      push_exp(ids[g], 8'h20 + 8'(ids[g]));
      wait_start(ok, lat);
      e = sb.pop_front();
      n_checks++;
      if (!ok || cur_id !== 2'(e.id) || tx_data !== e.data ||
          grant_ack !== (4'b0001 << e.id)) begin
        n_fail++;
        $display("FAIL fair_grant%0d: seen=%b id=%0d data=%h ack=%b, required id=%0d data=%h",
                 g, ok, cur_id, tx_data, grant_ack, e.id, e.data);
      end
      // Granted requester drops its bit; bit 2 stays pending after grant 1.
      req = (g == 1) ? 4'b0100 : 4'b0000;
      finish_frame(2);
    end
  endtask

  task automatic test_ignored_done();
    bit ok;
    int lat;
    bit bad;
    exp_t e;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done: busy=%b start=%b, required 0 0", busy, tx_start);
    end
    req = 4'b0010;
    push_exp(1, 8'h21);
    wait_start(ok, lat);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cur_id !== 2'(e.id) || tx_data !== e.data) begin
      n_fail++;
      $display("FAIL ign_grant: seen=%b id=%0d data=%h, required id=%0d data=%h", ok, cur_id,
               tx_data, e.id, e.data);
    end
    tx_done = 1'b1;
    req     = 4'b0000;
    @(negedge clk);
    tx_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < GAP + 4; i++) begin
      if (busy !== 1'b1 || tx_start !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL start_done: busy=%b start=%b, required still waiting (1 0)", busy,
               tx_start);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (4) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (GAP - 6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_done_busy: busy=%b at last gap cycle, required 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_done_idle: busy=%b start=%b, required 0 0", busy, tx_start);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int lat;
    exp_t e;
    set_data(8'h30);
    req = 4'b0010;
    push_exp(1, 8'h31);
    wait_start(ok, lat);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cur_id !== 2'(e.id) || tx_data !== e.data) begin
      n_fail++;
      $display("FAIL mrst_grant: seen=%b id=%0d data=%h, required id=%0d data=%h", ok, cur_id,
               tx_data, e.id, e.data);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({tx_start, busy, timeout} !== 3'b000 || grant_ack !== 4'b0000 ||
        tx_data !== 8'h00 || cur_id !== 2'd0) begin
      n_fail++;
      $display("FAIL mrst_outputs: start=%b busy=%b ack=%b data=%h id=%0d, required all 0",
               tx_start, busy, grant_ack, tx_data, cur_id);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_late_done: busy=%b start=%b, required 0 0", busy, tx_start);
    end
    req = 4'b1111;
    push_exp(0, 8'h30);
    wait_start(ok, lat);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cur_id !== 2'(e.id) || tx_data !== e.data ||
        grant_ack !== (4'b0001 << e.id)) begin
      n_fail++;
      $display("FAIL mrst_ptr: seen=%b id=%0d data=%h ack=%b, required id=%0d data=%h", ok,
               cur_id, tx_data, grant_ack, e.id, e.data);
    end
    req = 4'b0000;
    finish_frame(2);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int lat;
    bit bad_tmo;
    bit bad_busy;
    exp_t e;
    set_data(8'h40);
    req = 4'b0001;
    push_exp(0, 8'h40);
    wait_start(ok, lat);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cur_id !== 2'(e.id) || tx_data !== e.data) begin
      n_fail++;
      $display("FAIL tmo_grant: seen=%b id=%0d data=%h, required id=%0d data=%h", ok, cur_id,
               tx_data, e.id, e.data);
    end
    req = 4'b0000;
    bad_tmo  = 1'b0;
    bad_busy = 1'b0;
    // WAIT_DONE is entered in cycle 1 after START; the pulse lands TMO cycles later and the
    // gap then runs GAP cycles.
    for (int t = 1; t <= 1 + TMO + GAP + 1; t++) begin
      @(negedge clk);
      if (timeout !== (t == 1 + TMO)) bad_tmo = 1'b1;
      if (busy !== (t < 1 + TMO + GAP)) bad_busy = 1'b1;
    end
    n_checks++;
    if (bad_tmo) begin
      n_fail++;
      $display("FAIL tmo_pulse: o_timeout off its single cycle at %0d after WAIT_DONE entry",
               TMO);
    end
    n_checks++;
    if (bad_busy) begin
      n_fail++;
      $display("FAIL tmo_gap: busy not high through %0d gap cycles after timeout", GAP);
    end
    req = 4'b0010;
    push_exp(1, 8'h41);
    wait_start(ok, lat);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cur_id !== 2'(e.id) || tx_data !== e.data) begin
      n_fail++;
      $display("FAIL tmo_next: seen=%b id=%0d data=%h, required id=%0d data=%h", ok, cur_id,
               tx_data, e.id, e.data);
    end
    req = 4'b0000;
    finish_frame(3);
  endtask
`endif

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_fairness();
    test_ignored_done();
    test_mid_reset();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_txd transmitter between N_REQ byte requesters using round-robin arbitration.
- Sequences the transmitter: latches the winning byte, pulses i_tx_start for one cycle, waits for o_tx_done, then enforces an inter-frame idle gap before the next grant.
- Sits between the application byte sources and the UART TX datapath.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, byte width; must match the UART i_data width.
- GAP_CYCLES, 16, idle clk cycles after tx_done before the next grant (0 allowed).
- TIMEOUT_CYCLES, 200000, WAIT_DONE watchdog limit; used only with UART_ARB_TIMEOUT_EN.
- ID_W, derived: max(1, clog2(N_REQ)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_req  in  N_REQ  per-requester valid; bit k is held until o_grant_ack[k].
- i_req_data  in  N_REQ*DATA_W  requester k byte at bits [k*DATA_W +: DATA_W].
- o_grant_ack  out  N_REQ  one-hot 1-cycle pulse: byte of requester k accepted.
- o_tx_start  out  1  to UART i_tx_start; 1-cycle pulse.
- o_tx_data  out  DATA_W  to UART i_data; stable from o_tx_start until the next grant.
- i_tx_done  in  1  from UART o_tx_done.
- o_busy  out  1  high in every state except IDLE.
- o_cur_id  out  ID_W  index of the last granted requester.
- o_timeout  out  1  1-cycle pulse on watchdog expiry.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr 0; gap counter 0; watchdog 0.
- All outputs are registered.
- IDLE:
  - If any i_req bit is set at a clk edge, select the first set bit searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - At that same edge: latch o_tx_data and o_cur_id; set o_tx_start=1 and o_grant_ack[winner]=1; set rr_ptr=(winner+1) mod N_REQ; go to START.
  - Latency: request visible before edge k -> o_tx_start high in the cycle after edge k.
- START (1 cycle):
  - o_tx_start and o_grant_ack are high.
  - Next edge: both clear; go to WAIT_DONE.
  - i_tx_done is ignored in START.
- WAIT_DONE:
  - On i_tx_done=1: load gap counter with GAP_CYCLES and go to GAP. If GAP_CYCLES=0, go directly to IDLE.
- GAP:
  - Decrement the counter each cycle; when it reaches 1, go to IDLE at the next edge. Exactly GAP_CYCLES cycles are spent in GAP.
  - i_req is not sampled in GAP.
- i_tx_done arriving in IDLE or GAP: ignored, no state change.
- Requesters may drop i_req before ack. Only bits set in the IDLE sampling cycle compete.
- All requests pending: grant order is strictly k, k+1, ... wrapping at N_REQ-1 -> 0. No requester waits for more than N_REQ-1 other grants.
- rst during any state: at that edge return to IDLE with all outputs 0. The in-flight UART frame is abandoned and its later tx_done is ignored.
- o_tx_data and o_cur_id hold their last values through IDLE (not cleared except by rst).

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES without i_tx_done: o_timeout pulses for 1 cycle, the state goes to GAP (normal gap applies), and the watchdog clears.
  - The watchdog clears on entry to WAIT_DONE.
- Undefined:
  - No watchdog logic; o_timeout is tied to 0.
  - WAIT_DONE waits indefinitely for i_tx_done.

Test Plan:
- Single request: i_req=4'b0001, data0=8'hA5 -> next cycle o_tx_start=1, o_grant_ack=4'b0001, o_tx_data=8'hA5, o_cur_id=0. Then o_busy stays high until GAP_CYCLES=16 cycles after the i_tx_done pulse.
- Round-robin: i_req=4'b1111 held, re-raised after each ack, data k=8'h10+k -> grant order 0,1,2,3,0. Consecutive o_tx_start pulses are separated by (done delay + 16 + 2) cycles.
- Pointer fairness: grant to 2, then i_req=4'b0101 -> requester 0 wins (search starts at 3). Next, with i_req=4'b0101 still pending, requester 2 wins.
- Ignored done: i_tx_done pulse in IDLE and during the START cycle -> no state change, no spurious o_tx_start.
- Mid-frame reset: rst=1 for 1 cycle in WAIT_DONE -> all outputs 0 next cycle. A subsequent i_tx_done is ignored. A new request is granted normally starting from rr_ptr=0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50: no i_tx_done -> o_timeout pulses exactly 50 cycles after WAIT_DONE entry, then GAP, then the next grant proceeds.
